// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side burst controller for the project FIFO.
// Drains a requested number of words into a 2-entry in-order buffer drained by valid/ready.
module fifo_rd_ctrl #(
  parameter int WIDTH     = 8,
  parameter int FIFO_SIZE = 16,
  parameter int CNT_WIDTH = $clog2(FIFO_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_reads,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rdata,
  output logic                 fifo_rd_en,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] rd_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MaxLen  = CNT_WIDTH'(FIFO_SIZE);
  localparam logic [CNT_WIDTH-1:0] CntZero = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CntOne  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] issued_q, issued_d;
  logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q, inflight_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     buf0_q, buf0_d;
  logic [WIDTH-1:0]     buf1_q, buf1_d;

  logic                 valid_s;
  logic                 pop_s;
  logic                 rd_en_s;
  logic [2:0]           room_s;
  logic [CNT_WIDTH-1:0] clamp_s;
  logic [WIDTH-1:0]     head_s;

  // Handshake, read-issue decode and output head selection
  always_comb begin
    valid_s = (occ_q != 2'd0) || inflight_q;
    pop_s   = valid_s && out_ready;
    room_s  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    if (num_reads > MaxLen) begin
      clamp_s = MaxLen;
    end else begin
      clamp_s = num_reads;
    end
    if (state_q == READ) begin
      rd_en_s = !fifo_empty && (issued_q < len_q) && (room_s < 3'd2);
    end else begin
      rd_en_s = 1'b0;
    end
    // An empty buffer with a word in flight forwards the FIFO data directly,
    // giving one-cycle read latency without an extra stage.
    if ((occ_q == 2'd0) && inflight_q) begin
      head_s = fifo_rdata;
    end else begin
      head_s = buf0_q;
    end
  end

  // Buffer, counters and burst FSM next-state
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    done_d     = 1'b0;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    inflight_d = rd_en_s;
    issued_d   = rd_en_s ? (issued_q + CntOne) : issued_q;
    rd_count_d = pop_s ? (rd_count_q + CntOne) : rd_count_q;

    case ({inflight_q, pop_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    case (occ_q)
      2'd0: begin
        if (inflight_q && !pop_s) begin
          buf0_d = fifo_rdata;
        end else begin
          buf0_d = buf0_q;
        end
      end
      2'd1: begin
        if (inflight_q && pop_s) begin
          buf0_d = fifo_rdata;
        end else if (inflight_q) begin
          buf1_d = fifo_rdata;
        end else begin
          buf1_d = buf1_q;
        end
      end
      2'd2: begin
        if (pop_s) begin
          buf0_d = buf1_q;
        end else begin
          buf0_d = buf0_q;
        end
      end
      default: begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
      end
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          if (clamp_s != CntZero) begin
            len_d      = clamp_s;
            issued_d   = CntZero;
            rd_count_d = CntZero;
            state_d    = READ;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (issued_d == len_q) begin
          state_d = DRAIN;
        end else begin
          state_d = READ;
        end
      end
      DRAIN: begin
        // Finish on the edge of the last pop so done lands right after it.
        if ((occ_d == 2'd0) && !inflight_d) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q    <= IDLE;
      len_q      <= CntZero;
      issued_q   <= CntZero;
      rd_count_q <= CntZero;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      buf0_q     <= {WIDTH{1'b0}};
      buf1_q     <= {WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      rd_count_q <= rd_count_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  assign fifo_rd_en = rd_en_s;
  assign out_valid  = valid_s;
  assign out_data   = head_s;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign rd_count   = rd_count_q;

endmodule
